// File: rtl/rr_sel_sched_pkg.sv
// Shared types, sizes and the rotating-priority pick used by the
// round-robin chip-select scheduler.
package rr_sel_sched_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request scanning ptr, ptr+1, ... with natural 3-bit wrap.
  // The loop runs from the far end back toward ptr so the closest
  // candidate is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        p.valid = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_sel_sched_dec.sv
// Purely combinational 3-to-8 active-low decode with enable.
// All outputs high while en is low.
module sel_dec38
  import rr_sel_sched_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NREQ-1:0]  y_n
);

  // Drive the selected line low only when enabled.
  always_comb begin
    // NOTE: a default on every path first keeps this block free of latches.
    y_n = '1;
    if (en) y_n[sel] = 1'b0;
  end

endmodule

// File: rtl/rr_sel_sched.sv
// Round-robin scheduler for an 8-way shared chip-select decode.
// Grants one requester at a time, holds its strobe for ACCESS_CYCLES
// (stretched by wait_n on the last cycle), then inserts TURN_CYCLES
// dead cycles before the next arbitration.
module rr_sel_sched
  import rr_sel_sched_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int TURN_CYCLES   = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NREQ-1:0]  req,
  input  logic             wait_n,
  output logic [SEL_W-1:0] sel,
  output logic             sel_en,
  output logic [NREQ-1:0]  cs_n,
  output logic [NREQ-1:0]  ack,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD =
    CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  localparam bit HAS_TURN = (TURN_CYCLES > 0);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             sel_en_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [NREQ-1:0]  ack_n;
  pick_t            pick;
  logic             final_cyc;

  assign pick = rr_pick(req, ptr);

  // Last strobe cycle of a grant. A reset in this cycle kills the access,
  // so no acknowledge is reported for it.
  assign final_cyc = (state == ST_ACCESS) && (cnt == '0) && wait_n && !sys_rst;

  assign busy = (state == ST_ACCESS) || (state == ST_TURN);

  // Strobe decode from the registered select.
  sel_dec38 u_cs_dec (
    .sel (sel),
    .en  (sel_en),
    .y_n (cs_n)
  );

  // Same decode reused for the acknowledge, enabled only on the final cycle.
  sel_dec38 u_ack_dec (
    .sel (sel),
    .en  (final_cyc),
    .y_n (ack_n)
  );

  assign ack = ~ack_n;

  // Next-state and next-register values for arbitration, access and turnaround.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    sel_en_nxt = sel_en;
    cnt_nxt    = cnt;
    tcnt_nxt   = tcnt;
    ptr_nxt    = ptr;
    case (state)
      ST_IDLE: begin
        if (pick.valid) begin
          sel_nxt    = pick.idx;
          sel_en_nxt = 1'b1;
          cnt_nxt    = ACC_LOAD;
          state_nxt  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt != '0) begin
          // wait_n only matters once the minimum width has elapsed.
          cnt_nxt = cnt - 1'b1;
        end else if (wait_n) begin
          sel_en_nxt = 1'b0;
          ptr_nxt    = sel + 1'b1;
          if (HAS_TURN) begin
            state_nxt = ST_TURN;
            tcnt_nxt  = TURN_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        if (tcnt == '0) state_nxt = ST_IDLE;
        else            tcnt_nxt  = tcnt - 1'b1;
      end
      default: begin
        state_nxt  = ST_IDLE;
        sel_en_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (sys_rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      sel_en <= 1'b0;
      cnt    <= '0;
      tcnt   <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      sel_en <= sel_en_nxt;
      cnt    <= cnt_nxt;
      tcnt   <= tcnt_nxt;
      ptr    <= ptr_nxt;
    end
  end

endmodule

// File: doc/rr_sel_sched.md
Name: rr_sel_sched

Overview:
- Round-robin scheduler for a shared 8-way chip-select decode.
- Arbitrates 8 level requesters and drives a registered 3-bit select plus enable into a 3-to-8 active-low decode.
- Holds each granted strobe for a programmable access width, extended by a wait input, then inserts turnaround dead cycles.
- Sits between the internal bus masters and the per-target chip selects.

Parameters:
- ACCESS_CYCLES, 2, minimum cycles a strobe stays low per grant (legal range 1..15)
- TURN_CYCLES, 1, dead cycles with all strobes high after each access (legal range 0..15)

Ports:
- sys_clk  in  1  single system clock; all state updates on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- req  in  8  level request per requester; bit i = target i
- wait_n  in  1  active-low wait; extends the current access while low
- sel  out  3  registered index of the granted requester
- sel_en  out  1  registered strobe enable
- cs_n  out  8  active-low one-hot strobes = decode(sel, sel_en); all high when sel_en=0
- ack  out  8  one-cycle pulse on the final access cycle of requester i
- busy  out  1  high in ACCESS or TURN

Behaviour:
- Reset: on sys_clk edge with sys_rst=1, the block forces the following regardless of state:
  - state=IDLE, sel=0, sel_en=0, cs_n=8'hFF, ack=0, busy=0
  - priority pointer ptr=0, so requester 0 has highest priority
  - counters=0
  - Reset mid-access drops the strobe on the next edge; no ack is issued.
- IDLE:
  - Requests are sampled each cycle.
  - If any req bit is set, the winner is the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next edge: sel=winner, sel_en=1, cnt=ACCESS_CYCLES-1, state=ACCESS.
  - Grant latency is 1 cycle from the req sample.
- ACCESS:
  - cs_n[sel]=0 on every cycle.
  - The cycle is final when cnt==0 and wait_n==1:
    - ack[sel]=1 combinationally in that cycle.
    - Next edge: sel_en=0, ptr=sel+1 (3-bit wrap, 7->0).
    - Next state is TURN with tcnt=TURN_CYCLES-1, or IDLE if TURN_CYCLES=0.
  - cnt==0 with wait_n==0: stay in ACCESS, cnt held at 0, no ack.
  - cnt>0: cnt decrements every cycle. wait_n is ignored until cnt==0.
  - If req[sel] drops mid-access, the access still completes and ack is still pulsed. No abort.
- TURN:
  - cs_n all high, busy=1.
  - tcnt decrements; at tcnt==0 next state is IDLE.
- Minimum back-to-back period, no wait: 1 (arbitrate) + ACCESS_CYCLES + TURN_CYCLES.
- Requests arriving during ACCESS or TURN are only considered at the next IDLE sample.
- Simultaneous requests resolve strictly by the rotated scan. Every persistent requester is served within 8 grants.
- Invariants:
  - At most one cs_n bit is low in any cycle.
  - cs_n bit i is low only when sel==i and sel_en==1.
  - ack is one-hot or zero.
- Widths: cnt and tcnt are 4 bits; ptr and sel are 3 bits with natural wrap.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, TURN=2'd2)
  - NREQ=8, SEL_W=3, CNT_W=4
  - function rr_pick(req, ptr) returning a 3-bit index plus a valid flag
- One sub-module: sel_dec38, a purely combinational 3-to-8 active-low decode with enable. It is instantiated for cs_n and is reused for ack generation, gated by the final-cycle condition.

Test Plan:
- Reset then req=8'h04, wait_n=1, defaults:
  - cycle 1: sel=2, cs_n=8'hFB for 2 cycles
  - ack=8'h04 on the second cycle
  - 1 turn cycle with cs_n=8'hFF, then IDLE
- req=8'hFF held, defaults: grants follow 0,1,2,...,7,0, each spaced 4 cycles, with exactly one ack per grant.
- Grant to 3 with wait_n=0 from cnt==0 for 5 cycles: cs_n=8'hF7 lasts 2+5=7 cycles, and ack=8'h08 appears only in the cycle wait_n returns to 1.
- req=8'h81 with ptr=7: requester 7 wins first, then ptr wraps to 0 and requester 0 wins next.
- sys_rst=1 asserted in the second ACCESS cycle of requester 5:
  - next edge: cs_n=8'hFF, no ack pulse
  - after release with req=8'h20: requester 5 is re-granted in 1 cycle
- TURN_CYCLES=0, ACCESS_CYCLES=1, req=8'h03: alternating grants every 2 cycles, and cs_n never has two bits low in the same cycle.
